afu_axi_rd_arbiter: RTL and testbench
=====================================

# afu_axi_rd_arbiter

Shares one AXI4 read channel pair (AR/R) of a single memory bank between NUM_REQS independent read requesters inside the AFU, e.g. the Vortex core memory port, a host-side DMA prefetcher and the scope/debug readback path. Requesters are granted round-robin. Each requester is throttled by its own outstanding-burst counter. The requester index is embedded in the upper ARID bits, so responses are routed back by RID with no reorder buffering. The block instantiates once per bank, between the AFU wrapper's per-bank array signals and its read clients.

## Interface
Parameters:
- NUM_REQS, 4: number of requesters (≥2).
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 512: AXI data width.
- TAG_WIDTH, 8: per-requester tag width.
- MAX_PENDING, 16: maximum outstanding bursts per requester.
- Derived: REQ_SEL_W = CLOG2(NUM_REQS); ID_WIDTH = TAG_WIDTH + REQ_SEL_W; CNT_W = CLOG2(MAX_PENDING+1).

Ports:
- clk, in, 1: clock. Single clock domain.
- reset, in, 1: synchronous, active-high.
- req_valid, in, NUM_REQS: per-requester read request.
- req_ready, out, NUM_REQS: request accepted.
- req_addr, in, NUM_REQS×ADDR_WIDTH: burst address.
- req_len, in, NUM_REQS×8: AXI len (beats-1).
- req_tag, in, NUM_REQS×TAG_WIDTH: requester tag.
- rsp_valid, out, NUM_REQS: response beat valid.
- rsp_ready, in, NUM_REQS: response beat accept.
- rsp_data, out, DATA_WIDTH: shared response data.
- rsp_last, out, 1: shared last-beat flag.
- rsp_tag, out, TAG_WIDTH: RID[TAG_WIDTH-1:0].
- m_axi_arvalid / arready / araddr / arid / arlen: out / in / out ADDR_WIDTH / out ID_WIDTH / out 8.
- m_axi_rvalid / rready / rdata / rlast / rid / rresp: in / out / in DATA_WIDTH / in / in ID_WIDTH / in 2.
- rd_err, out, 1: sticky error (non-OKAY rresp, or bad RID).
- busy, out, 1: any burst outstanding or AR pending.

## Operation
- Eligibility: eligible[i] = req_valid[i] & (pend_cnt[i] != MAX_PENDING).
- AR output register (arvalid_q, araddr, arid, arlen) loads when arvalid_q==0 or arready==1.
- Grant: a round-robin arbiter over eligible. req_ready[i] = grant[i] & load_en. At most one bit of req_ready is set.
- On req fire: arid = {i, req_tag[i]}. The RR priority pointer moves to i+1 (mod NUM_REQS).
- No fire leaves the pointer unchanged. An asserted request waits at most NUM_REQS-1 grants.
- pend_cnt[i]:
  - +1 on AR fire (arvalid & arready) with arid index i.
  - −1 on R fire with rlast and rid index i.
  - Both in the same cycle: unchanged.
  - Counting is per accepted AR, not per request accept.
- R routing is combinational:
  - idx = rid[ID_WIDTH-1:TAG_WIDTH].
  - rsp_valid[idx] = rvalid.
  - m_axi_rready = rsp_ready[idx].
  - rsp_data, rsp_last and rsp_tag pass straight through.
- Bad RID (idx ≥ NUM_REQS): m_axi_rready = 1, the beat is dropped, rd_err is set.
- rresp != 0 on R fire: rd_err is set. The beat is still delivered.
- busy = arvalid_q | (OR of pend_cnt != 0).

## Timing
- Reset values:
  - arvalid_q = 0, araddr/arid/arlen = 0.
  - pend_cnt = 0, RR pointer = 0, rd_err = 0.
  - req_ready = 0, rsp_valid = 0, busy = 0.
- AR latency: req fire at cycle N gives m_axi_arvalid=1 at N+1.
- Back-to-back throughput is 1 AR/cycle while arready stays high.
- While arvalid_q=1 and arready=0, the AR register holds stable (AXI rule) and req_ready = 0.
- R path: 0-cycle latency. rvalid → rsp_valid in the same cycle.
- Throttle boundary: at pend_cnt == MAX_PENDING, requester i is masked the next cycle. The counter never exceeds MAX_PENDING because the AR register holds at most one unaccepted burst, and the count gates at grant using a counter that includes arvalid_q. Implement the gate as pend_cnt[i] + (arvalid_q & arid_idx==i) < MAX_PENDING.
- Underflow: an R-last fire for a requester with pend_cnt==0 sets rd_err and the counter stays 0.
- Reset mid-operation: everything clears the next cycle. Any in-flight R beats after reset are treated as bad-RID-free drops only if idx is valid; the counter saturates at 0 and rd_err is set.

## Structure
- No new package typedefs. REQ_SEL_W/ID_WIDTH are local derived params.
- Sub-module: VX_rr_arbiter for grant and pointer.
- Pop-free per-requester counters live in a generate loop.

## Test plan
- Single requester 0, addr 0x1000, len 3, tag 0x5A → arvalid at N+1 with arid {0,0x5A}. Four R beats route to rsp_valid[0] with rsp_tag 0x5A. pend_cnt returns to 0 and busy drops.
- All 4 requesters held valid, arready=1 → AR order 0,1,2,3,0,…; each req_ready pulses once per 4 cycles.
- arready=0 for 5 cycles with arvalid high → araddr/arid/arlen stable, all req_ready=0. On release, the next grant goes to the following requester.
- Requester 1 issues 16 bursts with no R → 17th held off (req_ready[1]=0) while requesters 0/2/3 keep being granted. One rlast for idx 1 → requester 1 is granted again.
- rresp=2'b10 on a beat for requester 2 → beat delivered, rd_err=1 and stays 1 until reset.
- rsp_ready[3]=0 while rvalid with idx 3 → m_axi_rready=0, beat held. Simultaneous AR fire and rlast for the same requester → pend_cnt unchanged.

Source files
------------

// File: rtl/afu_axi_rd_arbiter_pkg.sv
// Shared constants for the AFU AXI read arbiter.
//   AXI_LEN_W     : width of AXI ARLEN / requester len fields
//   AXI_RESP_W    : width of AXI RRESP
//   AXI_RESP_OKAY : RRESP encoding of a clean beat
package afu_axi_rd_arbiter_pkg;

    localparam int unsigned AXI_LEN_W     = 8;
    localparam int unsigned AXI_RESP_W    = 2;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/afu_axi_rd_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts at the priority pointer and wraps;
// the pointer moves to (winner + 1) mod NUM_REQS only when the grant is used.
//   clk, reset    : clock, synchronous active-high reset
//   requests      : per-requester eligibility
//   enable        : grant consumed this cycle (advances the pointer)
//   grant_onehot  : one-hot winner
//   grant_index   : binary winner index
//   grant_valid   : some requester won
module VX_rr_arbiter #(
    parameter int unsigned NUM_REQS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQS-1:0]         requests,
    input  logic                        enable,
    output logic [NUM_REQS-1:0]         grant_onehot,
    output logic [$clog2(NUM_REQS)-1:0] grant_index,
    output logic                        grant_valid
);

    localparam int unsigned SEL_W = $clog2(NUM_REQS);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    int unsigned      cand;

    always_comb begin
        grant_onehot = '0;
        grant_index  = '0;
        grant_valid  = 1'b0;
        cand         = 0;
        for (int unsigned off = 0; off < NUM_REQS; off++) begin
            cand = (32'(ptr_q) + off) % NUM_REQS;
            if (!grant_valid && requests[cand]) begin
                grant_valid        = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_index        = SEL_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (enable && grant_valid) begin
            ptr_d = (32'(grant_index) == NUM_REQS - 1) ? '0 : grant_index + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/afu_axi_rd_arbiter.sv
// Shares one AXI4 AR/R channel pair between NUM_REQS read requesters.
// Requests are granted round-robin into a one-deep AR register; the
// requester index rides in the upper ARID bits so R beats are routed back
// combinationally by RID. Each requester is throttled by its own count of
// accepted-but-unfinished bursts.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/ready/addr/len/tag : per-requester read request channel
//   rsp_valid/ready       : per-requester response handshake
//   rsp_data/last/tag     : shared response payload (from R)
//   m_axi_ar*, m_axi_r*   : AXI4 read master
//   rd_err                : sticky error (non-OKAY RRESP, bad RID, underflow)
//   busy                  : AR pending or any burst outstanding
module afu_axi_rd_arbiter
    import afu_axi_rd_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQS    = 4,
    parameter  int unsigned ADDR_WIDTH  = 32,
    parameter  int unsigned DATA_WIDTH  = 512,
    parameter  int unsigned TAG_WIDTH   = 8,
    parameter  int unsigned MAX_PENDING = 16,
    localparam int unsigned REQ_SEL_W   = $clog2(NUM_REQS),
    localparam int unsigned ID_WIDTH    = TAG_WIDTH + REQ_SEL_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQS-1:0]                    req_valid,
    output logic [NUM_REQS-1:0]                    req_ready,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQS-1:0][AXI_LEN_W-1:0]     req_len,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]     req_tag,
    output logic [NUM_REQS-1:0]                    rsp_valid,
    input  logic [NUM_REQS-1:0]                    rsp_ready,
    output logic [DATA_WIDTH-1:0]                  rsp_data,
    output logic                                   rsp_last,
    output logic [TAG_WIDTH-1:0]                   rsp_tag,
    output logic                                   m_axi_arvalid,
    input  logic                                   m_axi_arready,
    output logic [ADDR_WIDTH-1:0]                  m_axi_araddr,
    output logic [ID_WIDTH-1:0]                    m_axi_arid,
    output logic [AXI_LEN_W-1:0]                   m_axi_arlen,
    input  logic                                   m_axi_rvalid,
    output logic                                   m_axi_rready,
    input  logic [DATA_WIDTH-1:0]                  m_axi_rdata,
    input  logic                                   m_axi_rlast,
    input  logic [ID_WIDTH-1:0]                    m_axi_rid,
    input  logic [AXI_RESP_W-1:0]                  m_axi_rresp,
    output logic                                   rd_err,
    output logic                                   busy
);

    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

    // AR output register
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
    logic                  rd_err_q, rd_err_d;

    logic                  load_en, ar_fire, req_fire;
    logic [REQ_SEL_W-1:0]  ar_idx;
    logic [NUM_REQS-1:0]   eligible, grant_oh, pend_nz, underflow;
    logic [REQ_SEL_W-1:0]  grant_idx;
    logic                  grant_any;

    logic [REQ_SEL_W-1:0]  rid_idx;
    logic [31:0]           rid_idx_ext;
    logic                  rid_bad, r_fire;

    assign load_en = !arvalid_q || m_axi_arready;
    assign ar_fire = arvalid_q && m_axi_arready;
    assign ar_idx  = arid_q[ID_WIDTH-1:TAG_WIDTH];

    VX_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_rr_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (eligible),
        .enable       (load_en),
        .grant_onehot (grant_oh),
        .grant_index  (grant_idx),
        .grant_valid  (grant_any)
    );

    assign req_fire  = grant_any && load_en;
    assign req_ready = grant_oh & {NUM_REQS{load_en}};

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arid_d    = arid_q;
        arlen_d   = arlen_q;
        if (load_en) begin
            arvalid_d = req_fire;
            if (req_fire) begin
                araddr_d = req_addr[grant_idx];
                arid_d   = {grant_idx, req_tag[grant_idx]};
                arlen_d  = req_len[grant_idx];
            end
        end
    end

    // R routing; the index is widened so the range test stays meaningful
    // when NUM_REQS is not a power of two.
    assign rid_idx     = m_axi_rid[ID_WIDTH-1:TAG_WIDTH];
    assign rid_idx_ext = 32'(rid_idx);
    assign rid_bad     = rid_idx_ext >= NUM_REQS;

    always_comb begin
        rsp_valid    = '0;
        m_axi_rready = rid_bad;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (!rid_bad && rid_idx_ext == i) begin
                rsp_valid[i] = m_axi_rvalid;
                m_axi_rready = rsp_ready[i];
            end
        end
    end

    assign r_fire   = m_axi_rvalid && m_axi_rready;
    assign rsp_data = m_axi_rdata;
    assign rsp_last = m_axi_rlast;
    assign rsp_tag  = m_axi_rid[TAG_WIDTH-1:0];

    // Per-requester outstanding-burst counters. The gate counts a burst still
    // sitting in the AR register so the counter can never pass MAX_PENDING.
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_pend
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             inc, dec, in_ar;

        assign in_ar = arvalid_q && (ar_idx == REQ_SEL_W'(g));
        assign inc   = ar_fire && (ar_idx == REQ_SEL_W'(g));
        assign dec   = r_fire && m_axi_rlast && !rid_bad && (rid_idx == REQ_SEL_W'(g));

        assign eligible[g]  = req_valid[g] &&
            (({1'b0, cnt_q} + (CNT_W+1)'(in_ar)) < (CNT_W+1)'(MAX_PENDING));
        assign underflow[g] = dec && !inc && (cnt_q == '0);
        assign pend_nz[g]   = cnt_q != '0;

        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (dec && !inc && cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign rd_err_d = rd_err_q
                    || (r_fire && (rid_bad || m_axi_rresp != AXI_RESP_OKAY))
                    || (|underflow);

    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= '0;
            arlen_q   <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arid_q    <= arid_d;
            arlen_q   <= arlen_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_arlen   = arlen_q;
    assign rd_err        = rd_err_q;
    assign busy          = arvalid_q || (|pend_nz);

endmodule

// File: tb/tb_afu_axi_rd_arbiter.sv
// Directed bench for afu_axi_rd_arbiter (4 requesters, 64-bit data).
module tb_afu_axi_rd_arbiter;
    import afu_axi_rd_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 8;
    localparam int unsigned IW = TW + 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NR-1:0]            req_valid, req_ready;
    logic [NR-1:0][AW-1:0]    req_addr;
    logic [NR-1:0][7:0]       req_len;
    logic [NR-1:0][TW-1:0]    req_tag;
    logic [NR-1:0]            rsp_valid, rsp_ready;
    logic [DW-1:0]            rsp_data;
    logic                     rsp_last;
    logic [TW-1:0]            rsp_tag;
    logic                     arvalid, arready;
    logic [AW-1:0]            araddr;
    logic [IW-1:0]            arid;
    logic [7:0]               arlen;
    logic                     rvalid, rready, rlast;
    logic [DW-1:0]            rdata;
    logic [IW-1:0]            rid;
    logic [1:0]               rresp;
    logic                     rd_err, busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    afu_axi_rd_arbiter #(
        .NUM_REQS    (NR),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TAG_WIDTH   (TW),
        .MAX_PENDING (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_tag       (req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .rsp_tag       (rsp_tag),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_araddr  (araddr),
        .m_axi_arid    (arid),
        .m_axi_arlen   (arlen),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axi_rdata   (rdata),
        .m_axi_rlast   (rlast),
        .m_axi_rid     (rid),
        .m_axi_rresp   (rresp),
        .rd_err        (rd_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        req_tag   = '0;
        rsp_ready = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rlast     = 1'b0;
        rid       = '0;
        rresp     = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_araddr", 64'(araddr), 64'd0);
        check("rst_arid", 64'(arid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_err", 64'(rd_err), 64'd0);

        // ---------------- single request, 4-beat burst ----------------
        req_valid   = 4'b0001;
        req_addr[0] = 32'h1000;
        req_len[0]  = 8'd3;
        req_tag[0]  = 8'h5A;
        #1;
        check("a_req_ready", 64'(req_ready), 64'h1);
        tick();
        check("a_arvalid", 64'(arvalid), 64'd1);
        check("a_araddr", 64'(araddr), 64'h1000);
        check("a_arid", 64'(arid), 64'h05A);
        check("a_arlen", 64'(arlen), 64'd3);
        check("a_busy_ar", 64'(busy), 64'd1);
        req_valid = '0;
        arready   = 1'b1;
        #1;
        check("a_req_ready_idle", 64'(req_ready), 64'd0);
        tick();
        check("a_arvalid_done", 64'(arvalid), 64'd0);
        check("a_busy_pend", 64'(busy), 64'd1);
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid    = 1'b1;
            rid       = 10'h05A;
            rdata     = 64'hD0 + 64'(b);
            rlast     = (b == 3);
            rsp_ready = 4'b0001;
            #1;
            check("a_rsp_valid", 64'(rsp_valid), 64'h1);
            check("a_rsp_tag", 64'(rsp_tag), 64'h5A);
            check("a_rsp_data", rsp_data, 64'hD0 + 64'(b));
            check("a_rsp_last", 64'(rsp_last), 64'(b == 3));
            check("a_rready", 64'(rready), 64'd1);
            tick();
        end
        idle_inputs();
        #1;
        check("a_busy_end", 64'(busy), 64'd0);
        check("a_rd_err", 64'(rd_err), 64'd0);

        // ---------------- round robin with all requesters valid ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 32'(32'h100 * (i + 1));
            req_len[i]  = 8'(i);
            req_tag[i]  = 8'(8'h10 + i);
        end
        req_valid = 4'b1111;
        arready   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_req_ready", 64'(req_ready), 64'(1 << (k % 4)));
            tick();
            check("rr_arid", 64'(arid), 64'(((k % 4) << 8) | (8'h10 + (k % 4))));
        end
        // AR stall: requester 3's burst holds in the register
        arready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_arvalid", 64'(arvalid), 64'd1);
            check("stall_araddr", 64'(araddr), 64'h400);
            check("stall_arid", 64'(arid), 64'h313);
            check("stall_arlen", 64'(arlen), 64'd3);
            tick();
        end
        arready = 1'b1;
        #1;
        check("stall_release", 64'(req_ready), 64'h1);
        tick();
        idle_inputs();

        // ---------------- throttle at MAX_PENDING ----------------
        do_reset();
        req_tag[1] = 8'h77;
        req_valid  = 4'b0010;
        arready    = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("thr_grant", 64'(req_ready), 64'h2);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        check("thr_skip_a", 64'(req_ready), 64'h4);
        tick();
        check("thr_skip_b", 64'(req_ready), 64'h8);
        tick();
        check("thr_skip_c", 64'(req_ready), 64'h1);
        tick();
        check("thr_skip_d", 64'(req_ready), 64'h4);
        tick();
        req_valid = 4'b0010;
        #1;
        check("thr_held", 64'(req_ready), 64'd0);
        tick();
        rvalid    = 1'b1;
        rid       = 10'h177;
        rlast     = 1'b1;
        rsp_ready = 4'b0010;
        #1;
        check("thr_rsp_valid", 64'(rsp_valid), 64'h2);
        check("thr_held_r", 64'(req_ready), 64'd0);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        check("thr_regrant", 64'(req_ready), 64'h2);
        tick();
        idle_inputs();

        // ---------------- rresp error ----------------
        do_reset();
        rvalid    = 1'b1;
        rid       = 10'h233;
        rresp     = 2'b10;
        rsp_ready = 4'b0100;
        #1;
        check("err_rsp_valid", 64'(rsp_valid), 64'h4);
        check("err_rready", 64'(rready), 64'd1);
        check("err_rsp_tag", 64'(rsp_tag), 64'h33);
        check("err_before", 64'(rd_err), 64'd0);
        tick();
        idle_inputs();
        #1;
        check("err_set", 64'(rd_err), 64'd1);
        tick();
        tick();
        check("err_sticky", 64'(rd_err), 64'd1);
        do_reset();
        check("err_cleared", 64'(rd_err), 64'd0);

        // ---------------- backpressure and simultaneous inc/dec ----------------
        rvalid    = 1'b1;
        rid       = 10'h3AB;
        rsp_ready = 4'b0111;
        #1;
        check("bp_rsp_valid", 64'(rsp_valid), 64'h8);
        check("bp_rready", 64'(rready), 64'd0);
        tick();
        check("bp_held", 64'(rsp_valid), 64'h8);
        check("bp_no_err", 64'(rd_err), 64'd0);
        rvalid     = 1'b0;
        req_tag[3] = 8'hAB;
        req_valid  = 4'b1000;
        #1;
        check("sim_grant1", 64'(req_ready), 64'h8);
        tick();
        arready = 1'b1;
        #1;
        check("sim_grant2", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        rvalid    = 1'b1;
        rlast     = 1'b1;
        rsp_ready = 4'b1000;
        #1;
        check("sim_rready", 64'(rready), 64'd1);
        check("sim_ar_pending", 64'(arvalid), 64'd1);
        tick();
        rvalid = 1'b0;
        #1;
        check("sim_arvalid", 64'(arvalid), 64'd0);
        check("sim_busy", 64'(busy), 64'd1);
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        #1;
        check("sim_drained", 64'(busy), 64'd0);
        check("sim_no_err", 64'(rd_err), 64'd0);
        // R-last with nothing outstanding
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        #1;
        check("underflow_err", 64'(rd_err), 64'd1);
        check("underflow_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
